// File: rtl/boid_frame_scanner_if.sv
// Pixel write port between the frame scanner and the VGA frame buffer.
// Valid/ready: a write is accepted on a clock edge where pix_wr_en and pix_ready are both 1.
interface boid_frame_scanner_if #(
    parameter int unsigned ADDR_W = 19
) ();
    logic              pix_wr_en;
    logic [ADDR_W-1:0] pix_addr;
    logic [7:0]        pix_data;
    logic              pix_ready;

    modport master (
        output pix_wr_en,
        output pix_addr,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_wr_en,
        input  pix_addr,
        input  pix_data,
        output pix_ready
    );
endinterface

// File: rtl/boid_frame_scanner.sv
// Boid frame scanner: sweeps every pixel in raster order, queries the boid memory
// for occupancy and streams one colour write per pixel into the frame buffer.
module boid_frame_scanner #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter logic [7:0]  BG_COLOR   = 8'h00,
    parameter logic [7:0]  BOID_COLOR = 8'hFF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 x_chk_out,
    output logic [31:0]                 y_chk_out,
    input  logic                        is_boid_here,
    boid_frame_scanner_if.master        pix,
    output logic [15:0]                 frame_count
);

    localparam int unsigned XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
    localparam int unsigned YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t            state;
    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic              advance;

    // The output register can take a new pixel when it is empty or being drained this edge.
    assign advance = !pix.pix_wr_en || pix.pix_ready;

    // The memory compare runs on the pixel that will be loaded next.
    assign x_chk_out = 32'(x_chk_cnt(x_cnt));
    assign y_chk_out = 32'(y_chk_cnt(y_cnt));

    function automatic logic [XW-1:0] x_chk_cnt(input logic [XW-1:0] v);
        return v;
    endfunction

    function automatic logic [YW-1:0] y_chk_cnt(input logic [YW-1:0] v);
        return v;
    endfunction

    // Frame FSM with registered handshake, status and raster counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pix.pix_wr_en <= 1'b0;
            pix.pix_addr  <= '0;
            pix.pix_data  <= '0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            addr_cnt      <= '0;
            frame_count   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SCAN;
                        busy     <= 1'b1;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        addr_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        pix.pix_wr_en <= 1'b1;
                        pix.pix_addr  <= addr_cnt;
                        pix.pix_data  <= is_boid_here ? BOID_COLOR : BG_COLOR;
                        addr_cnt      <= addr_cnt + ADDR_W'(1);
                        if (x_cnt == XW'(SCREEN_W - 1)) begin
                            if (y_cnt == YW'(SCREEN_H - 1)) begin
                                // Last pixel loaded; counters hold until the frame closes.
                                state <= DRAIN;
                            end else begin
                                x_cnt <= '0;
                                y_cnt <= y_cnt + YW'(1);
                            end
                        end else begin
                            x_cnt <= x_cnt + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pix.pix_ready) begin
                        pix.pix_wr_en <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        frame_count   <= frame_count + 16'd1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    x_cnt    <= '0;
                    y_cnt    <= '0;
                    addr_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boid_frame_scanner.sv
// Self-checking bench for boid_frame_scanner on a 4x3 screen with one boid at (2,1).
module tb_boid_frame_scanner;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] x_chk_out;
    logic [31:0] y_chk_out;
    logic        is_boid_here;
    logic [15:0] frame_count;

    boid_frame_scanner_if #(.ADDR_W(4)) pix ();

    boid_frame_scanner #(
        .SCREEN_W   (W),
        .SCREEN_H   (H),
        .ADDR_W     (4),
        .BG_COLOR   (8'h00),
        .BOID_COLOR (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .x_chk_out    (x_chk_out),
        .y_chk_out    (y_chk_out),
        .is_boid_here (is_boid_here),
        .pix          (pix),
        .frame_count  (frame_count)
    );

    // Boid memory model: a single boid at (2,1).
    assign is_boid_here = (x_chk_out == 32'd2) && (y_chk_out == 32'd1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          accepted = 0;
    int          stall_left = 0;
    logic [15:0] fc_model = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the middle of the next cycle, drive that cycle's inputs and score any write
    // the frame buffer accepts at the coming edge.
    task automatic cycle(input logic st, input logic rdy);
        exp_t e;
        @(negedge clk);
        cyc++;
        if (stall_left > 0 && pix.pix_wr_en === 1'b1 && pix.pix_addr === 4'd5) begin
            rdy = 1'b0;
            stall_left--;
        end
        start         = st;
        pix.pix_ready = rdy;
        if (pix.pix_wr_en === 1'b1 && rdy) begin
            accepted++;
            chk("sb_has_entry", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(pix.pix_addr), e.addr);
                chk("wr_data", 32'(pix.pix_data), e.data);
                if (e.cyc >= 0) chk("wr_cycle", cyc, e.cyc);
            end
        end
    endtask

    task automatic push_frame(input int base, input int stall_cycles, input bit timed);
        for (int i = 0; i < W * H; i++) begin
            exp_q.push_back('{addr: i,
                              data: (i == 6) ? 32'hFF : 32'h00,
                              cyc:  timed ? base + 2 + i + ((i >= 5) ? stall_cycles : 0) : -1});
        end
    endtask

    // One frame: start in relative cycle 0, a stray start in cycle 4, optional start in the
    // DONE cycle, optional back-pressure while addr 5 is presented.
    task automatic run_frame(input int stall_cycles, input bit start_in_done);
        int base;
        int done_seen;
        int acc0;
        int hold5;
        int done_k;
        base      = cyc + 1;
        done_k    = W * H + 2 + stall_cycles;
        push_frame(base, stall_cycles, 1'b1);
        stall_left = stall_cycles;
        acc0      = accepted;
        hold5     = 0;
        done_seen = -1;
        cycle(1'b1, 1'b1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_wr_en", pix.pix_wr_en, 0);
        for (int k = 1; k <= done_k + 4 && done_seen < 0; k++) begin
            cycle((k == 4) || (start_in_done && k == done_k), 1'b1);
            if (done === 1'b1) done_seen = k;
            if (pix.pix_wr_en === 1'b1 && pix.pix_addr === 4'd5) begin
                hold5++;
                chk("hold_x", x_chk_out, 2);
                chk("hold_y", y_chk_out, 1);
            end
            if (k == 1) chk("busy_first_scan", busy, 1);
            if (k == done_k - 1) chk("busy_last_write", busy, 1);
        end
        fc_model = fc_model + 16'd1;
        chk("done_cycle", done_seen, done_k);
        chk("done_busy", busy, 0);
        chk("done_wr_en", pix.pix_wr_en, 0);
        chk("frame_count", frame_count, fc_model);
        chk("accepted", accepted - acc0, W * H);
        chk("addr5_cycles", hold5, 1 + stall_cycles);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        pix.pix_ready = 1'b1;

        // Reset state.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", pix.pix_wr_en, 0);
        chk("rst_addr", 32'(pix.pix_addr), 0);
        chk("rst_x", x_chk_out, 0);
        chk("rst_y", y_chk_out, 0);
        chk("rst_frame_count", frame_count, 0);
        reset = 1'b1;
        cycle(1'b0, 1'b1);

        // Nominal frame with ignored starts in cycles 4 and 14.
        run_frame(0, 1'b1);
        // Start right after done; back-pressure on addr 5.
        run_frame(3, 1'b0);

        // Mid-frame reset while addr 7 is valid.
        push_frame(0, 0, 1'b0);
        cycle(1'b1, 1'b1);
        for (int k = 0; k < 20 && !(pix.pix_wr_en === 1'b1 && pix.pix_addr === 4'd7); k++)
            cycle(1'b0, 1'b1);
        chk("reach_addr7", 32'(pix.pix_addr), 7);
        reset = 1'b0;
        #1;
        chk("mid_rst_wr_en", pix.pix_wr_en, 0);
        chk("mid_rst_busy", busy, 0);
        exp_q.delete();
        cycle(1'b0, 1'b1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_frame_count", frame_count, 0);
        reset    = 1'b1;
        fc_model = 16'd0;
        cycle(1'b0, 1'b1);
        chk("post_rst_wr_en", pix.pix_wr_en, 0);
        run_frame(0, 1'b0);

        // Wrap: preload 65535 completed frames.
        force dut.frame_count = 16'hFFFF;
        cycle(1'b0, 1'b1);
        release dut.frame_count;
        cycle(1'b0, 1'b1);
        chk("preload", frame_count, 16'hFFFF);
        fc_model = 16'hFFFF;
        run_frame(0, 1'b0);
        chk("wrap_zero", frame_count, 0);

        cycle(1'b0, 1'b1);
        chk("final_done_low", done, 0);
        chk("final_wr_en", pix.pix_wr_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
